// File: rtl/cp0_unit.sv
// Coprocessor-0 beside the MEM stage: exception/interrupt request, SR/Cause/EPC, mfc0/mtc0, eret.
// Optional build macro CP0_PRID_EN makes register 15 return a read-only processor ID.
module cp0_unit #(
    parameter logic [31:0] SR_WMASK   = 32'h0000_FC03
`ifdef CP0_PRID_EN
    ,
    parameter logic [31:0] PRID_VALUE = 32'h4D49_5053
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPC_out,
    output logic        Req
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_src;

    // EXL blocks every new request, so a handler can never be re-entered.
    assign int_req = (|(HWInt & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
    assign exc_req = (ExcCodeIn != 5'd0) & ~sr_q[1];
    assign Req     = ~reset & (int_req | exc_req);
    assign epc_src = BDIn ? (VPC - 32'd4) : VPC;

    always_comb begin
        sr_d             = sr_q;
        cause_d          = cause_q;
        epc_d            = epc_q;
        cause_d[15:10]   = HWInt;
        if (Req) begin
            sr_d[1]       = 1'b1;
            cause_d[6:2]  = int_req ? 5'd0 : ExcCodeIn;
            cause_d[31]   = BDIn;
            epc_d         = epc_src & 32'hFFFF_FFFC;
        end else begin
            if (en) begin
                case (CP0Add)
                    5'd12:   sr_d  = (sr_q & ~SR_WMASK) | (CP0In & SR_WMASK);
                    5'd14:   epc_d = CP0In & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
            // eret is applied after the mtc0 so it wins on the EXL bit.
            if (EXLClr) begin
                sr_d[1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= 32'd0;
            cause_q <= 32'd0;
            epc_q   <= 32'd0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            5'd12:   CP0Out = sr_q;
            5'd13:   CP0Out = cause_q;
            5'd14:   CP0Out = epc_q;
`ifdef CP0_PRID_EN
            5'd15:   CP0Out = PRID_VALUE;
`endif
            default: CP0Out = 32'd0;
        endcase
    end

    assign EPC_out = epc_q;

endmodule
